// File: rtl/ibex_sram_arbiter_if.sv
// Ibex instruction/data ports plus the single-port SRAM port, bundled for the arbiter.
// The arbiter uses slave; whatever drives the Ibex requests and the SRAM read data uses master.
interface ibex_sram_arbiter_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  mem_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output mem_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/ibex_sram_arbiter.sv
// Ibex instr/data share one SRAM: same-cycle grant, rvalid one cycle later, no stall beyond losing arbitration.
// Instr streaks are capped while data waits; ARB_PERF_CNT_EN adds grant/stall counters.
module ibex_sram_arbiter #(
  parameter logic [31:0] MemStart       = 32'h0000_0000,
  parameter logic [31:0] MemMask        = 32'h0000_FFFF,
  parameter int unsigned MaxInstrStreak = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ibex_sram_arbiter_if.slave    bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_instr_gnt_o,
  output logic [31:0]           perf_data_gnt_o,
  output logic [31:0]           perf_data_stall_o
`endif
);

  typedef enum logic {OWN_INSTR = 1'b0, OWN_DATA = 1'b1} owner_e;

  localparam logic [3:0] STREAK_MAX = 4'(MaxInstrStreak);

  logic        r_rsp_valid;
  owner_e      r_rsp_owner;
  logic        r_rsp_err;
  logic [3:0]  r_streak;

  logic        w_data_win;
  logic        w_instr_win;
  logic        w_any_win;
  logic [31:0] w_addr;
  logic        w_hit;
  logic        w_rsp_ok;

  always_comb begin
    w_data_win  = bus.data_req_i && (!bus.instr_req_i || (r_streak == STREAK_MAX));
    w_instr_win = bus.instr_req_i && !w_data_win;
    w_any_win   = w_data_win || w_instr_win;
    w_addr      = 32'h0;
    if (w_data_win) begin
      w_addr = bus.data_addr_i;
    end else if (w_instr_win) begin
      w_addr = bus.instr_addr_i;
    end
    w_hit = ((w_addr & ~MemMask) == MemStart);
  end

  assign bus.instr_gnt_o = w_instr_win;
  assign bus.data_gnt_o  = w_data_win;

  assign bus.mem_req_o   = w_any_win && w_hit;
  assign bus.mem_addr_o  = w_addr;
  assign bus.mem_we_o    = w_data_win ? bus.data_we_i    : 1'b0;
  assign bus.mem_be_o    = w_data_win ? bus.data_be_i    : 4'h0;
  assign bus.mem_wdata_o = w_data_win ? bus.data_wdata_i : 32'h0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= OWN_INSTR;
      r_rsp_err   <= 1'b0;
      r_streak    <= 4'd0;
    end else begin
      r_rsp_valid <= w_any_win;
      r_rsp_owner <= w_data_win ? OWN_DATA : OWN_INSTR;
      r_rsp_err   <= w_any_win && !w_hit;
      // Only a fetch that beats a waiting data request extends the streak.
      if (w_instr_win && bus.data_req_i) begin
        if (r_streak != STREAK_MAX) begin
          r_streak <= r_streak + 4'd1;
        end
      end else begin
        r_streak <= 4'd0;
      end
    end
  end

  // Error responses return zero rather than whatever the idle SRAM drives.
  assign w_rsp_ok = r_rsp_valid && !r_rsp_err;

  assign bus.instr_rvalid_o = r_rsp_valid && (r_rsp_owner == OWN_INSTR);
  assign bus.data_rvalid_o  = r_rsp_valid && (r_rsp_owner == OWN_DATA);
  assign bus.instr_err_o    = r_rsp_valid && r_rsp_err && (r_rsp_owner == OWN_INSTR);
  assign bus.data_err_o     = r_rsp_valid && r_rsp_err && (r_rsp_owner == OWN_DATA);
  assign bus.instr_rdata_o  = w_rsp_ok ? bus.mem_rdata_i : 32'h0;
  assign bus.data_rdata_o   = w_rsp_ok ? bus.mem_rdata_i : 32'h0;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_instr_gnt;
  logic [31:0] r_perf_data_gnt;
  logic [31:0] r_perf_data_stall;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_perf_instr_gnt  <= 32'h0;
      r_perf_data_gnt   <= 32'h0;
      r_perf_data_stall <= 32'h0;
    end else begin
      if (w_instr_win) r_perf_instr_gnt <= r_perf_instr_gnt + 32'd1;
      if (w_data_win)  r_perf_data_gnt  <= r_perf_data_gnt + 32'd1;
      if (bus.data_req_i && !w_data_win) r_perf_data_stall <= r_perf_data_stall + 32'd1;
    end
  end

  assign perf_instr_gnt_o  = r_perf_instr_gnt;
  assign perf_data_gnt_o   = r_perf_data_gnt;
  assign perf_data_stall_o = r_perf_data_stall;
`endif

endmodule

// File: tb/tb_ibex_sram_arbiter.sv
// Directed checks of grant, routing, error, starvation and reset behaviour of ibex_sram_arbiter.
module tb_ibex_sram_arbiter;
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  ibex_sram_arbiter_if bus_if ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_instr_gnt_o, perf_data_gnt_o, perf_data_stall_o;
  logic [31:0] base_i, base_d, base_s;
`endif

  ibex_sram_arbiter #(
    .MemStart       (32'h0000_0000),
    .MemMask        (32'h0000_FFFF),
    .MaxInstrStreak (4)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus_if.slave)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_instr_gnt_o  (perf_instr_gnt_o),
    .perf_data_gnt_o   (perf_data_gnt_o),
    .perf_data_stall_o (perf_data_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then let combinational outputs settle.
  task automatic set_cycle(input logic ireq, input logic [31:0] iaddr,
                           input logic dreq, input logic dwe, input logic [3:0] dbe,
                           input logic [31:0] daddr, input logic [31:0] dwdata,
                           input logic [31:0] mrd);
    @(negedge clk_i);
    bus_if.instr_req_i  = ireq;
    bus_if.instr_addr_i = iaddr;
    bus_if.data_req_i   = dreq;
    bus_if.data_we_i    = dwe;
    bus_if.data_be_i    = dbe;
    bus_if.data_addr_i  = daddr;
    bus_if.data_wdata_i = dwdata;
    bus_if.mem_rdata_i  = mrd;
    #1;
  endtask

  task automatic idle();
    set_cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    bus_if.instr_req_i  = 1'b0;
    bus_if.instr_addr_i = 32'h0;
    bus_if.data_req_i   = 1'b0;
    bus_if.data_we_i    = 1'b0;
    bus_if.data_be_i    = 4'h0;
    bus_if.data_addr_i  = 32'h0;
    bus_if.data_wdata_i = 32'h0;
    bus_if.mem_rdata_i  = 32'h0;

    // Reset state
    idle();
    idle();
    chk("rst_instr_rvalid", 32'(bus_if.instr_rvalid_o), 32'd0);
    chk("rst_data_rvalid",  32'(bus_if.data_rvalid_o),  32'd0);
    chk("rst_instr_err",    32'(bus_if.instr_err_o),    32'd0);
    chk("rst_data_err",     32'(bus_if.data_err_o),     32'd0);
    chk("rst_gnts",         32'({bus_if.instr_gnt_o, bus_if.data_gnt_o}), 32'd0);
    chk("rst_mem_req",      32'(bus_if.mem_req_o),      32'd0);
    chk("rst_mem_addr",     bus_if.mem_addr_o,          32'd0);
    rst_ni = 1'b1;
    idle();

    // Instruction-only stream
    set_cycle(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    chk("io_gnt0",     32'(bus_if.instr_gnt_o), 32'd1);
    chk("io_dgnt0",    32'(bus_if.data_gnt_o),  32'd0);
    chk("io_memreq0",  32'(bus_if.mem_req_o),   32'd1);
    chk("io_memaddr0", bus_if.mem_addr_o,       32'h80);
    chk("io_memwe0",   32'(bus_if.mem_we_o),    32'd0);
    chk("io_rvalid0",  32'(bus_if.instr_rvalid_o), 32'd0);
    set_cycle(1'b1, 32'h84, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hA);
    chk("io_gnt1",     32'(bus_if.instr_gnt_o),    32'd1);
    chk("io_rvalid1",  32'(bus_if.instr_rvalid_o), 32'd1);
    chk("io_rdata1",   bus_if.instr_rdata_o,       32'hA);
    chk("io_drvalid1", 32'(bus_if.data_rvalid_o),  32'd0);
    set_cycle(1'b1, 32'h88, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hB);
    chk("io_rvalid2",  32'(bus_if.instr_rvalid_o), 32'd1);
    chk("io_rdata2",   bus_if.instr_rdata_o,       32'hB);
    chk("io_drvalid2", 32'(bus_if.data_rvalid_o),  32'd0);
    set_cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hC);
    chk("io_rvalid3",  32'(bus_if.instr_rvalid_o), 32'd1);
    chk("io_rdata3",   bus_if.instr_rdata_o,       32'hC);
    chk("io_gnt3",     32'(bus_if.instr_gnt_o),    32'd0);
    chk("io_memreq3",  32'(bus_if.mem_req_o),      32'd0);
    chk("io_drvalid3", 32'(bus_if.data_rvalid_o),  32'd0);
    idle();
    chk("io_rvalid4",  32'(bus_if.instr_rvalid_o), 32'd0);

    // Data write
    set_cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEADBEEF, 32'h0);
    chk("dw_gnt",      32'(bus_if.data_gnt_o),  32'd1);
    chk("dw_igntoff",  32'(bus_if.instr_gnt_o), 32'd0);
    chk("dw_memreq",   32'(bus_if.mem_req_o),   32'd1);
    chk("dw_memwe",    32'(bus_if.mem_we_o),    32'd1);
    chk("dw_membe",    32'(bus_if.mem_be_o),    32'h3);
    chk("dw_memaddr",  bus_if.mem_addr_o,       32'h100);
    chk("dw_memwdata", bus_if.mem_wdata_o,      32'hDEADBEEF);
    set_cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h1234);
    chk("dw_rvalid",   32'(bus_if.data_rvalid_o),  32'd1);
    chk("dw_err",      32'(bus_if.data_err_o),     32'd0);
    chk("dw_rdata",    bus_if.data_rdata_o,        32'h1234);
    chk("dw_irvalid",  32'(bus_if.instr_rvalid_o), 32'd0);
    idle();

    // Starvation limiter: I,I,I,I,D repeating
`ifdef ARB_PERF_CNT_EN
    base_i = perf_instr_gnt_o;
    base_d = perf_data_gnt_o;
    base_s = perf_data_stall_o;
`endif
    for (int i = 0; i < 10; i++) begin
      set_cycle(1'b1, 32'h200 + 32'(i * 4), 1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 32'h0);
      chk($sformatf("sv_dgnt%0d", i), 32'(bus_if.data_gnt_o),  32'((i % 5) == 4));
      chk($sformatf("sv_ignt%0d", i), 32'(bus_if.instr_gnt_o), 32'((i % 5) != 4));
      chk($sformatf("sv_addr%0d", i), bus_if.mem_addr_o,
          ((i % 5) == 4) ? 32'h300 : 32'h200 + 32'(i * 4));
    end
    idle();
`ifdef ARB_PERF_CNT_EN
    chk("perf_instr_gnt",  perf_instr_gnt_o  - base_i, 32'd8);
    chk("perf_data_gnt",   perf_data_gnt_o   - base_d, 32'd2);
    chk("perf_data_stall", perf_data_stall_o - base_s, 32'd8);
`endif
    idle();

    // Out-of-window accesses
    set_cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h20000, 32'h0, 32'h0);
    chk("oow_dgnt",   32'(bus_if.data_gnt_o), 32'd1);
    chk("oow_memreq", 32'(bus_if.mem_req_o),  32'd0);
    set_cycle(1'b1, 32'h10000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h55AA);
    chk("oow_drvalid", 32'(bus_if.data_rvalid_o), 32'd1);
    chk("oow_derr",    32'(bus_if.data_err_o),    32'd1);
    chk("oow_drdata",  bus_if.data_rdata_o,       32'h0);
    chk("oow_ignt",    32'(bus_if.instr_gnt_o),   32'd1);
    chk("oow_imemreq", 32'(bus_if.mem_req_o),     32'd0);
    set_cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h77);
    chk("oow_irvalid", 32'(bus_if.instr_rvalid_o), 32'd1);
    chk("oow_ierr",    32'(bus_if.instr_err_o),    32'd1);
    chk("oow_irdata",  bus_if.instr_rdata_o,       32'h0);
    chk("oow_dclear",  32'(bus_if.data_err_o),     32'd0);
    idle();

    // Reset mid-transaction after building an instr streak
    set_cycle(1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h44, 32'h0, 32'h0);
    set_cycle(1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h44, 32'h0, 32'h0);
    set_cycle(1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h44, 32'h0, 32'h0);
    chk("rm_ignt", 32'(bus_if.instr_gnt_o), 32'd1);
    rst_ni = 1'b0;
    set_cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h99);
    chk("rm_irvalid", 32'(bus_if.instr_rvalid_o), 32'd0);
    chk("rm_drvalid", 32'(bus_if.data_rvalid_o),  32'd0);
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_cycle(1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h44, 32'h0, 32'h0);
      chk($sformatf("rm_dgnt%0d", i), 32'(bus_if.data_gnt_o), 32'(i == 4));
      if (i == 0) chk("rm_irvalid_post", 32'(bus_if.instr_rvalid_o), 32'd0);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ibex_sram_arbiter.md
Name: ibex_sram_arbiter

Overview:
Shares one single-port SRAM (ram_1p-style: request in cycle N, read data and rvalid in N+1) between the Ibex instruction and data ports. Grants with same-cycle gnt. Routes each response back to the port that issued it. Out-of-window accesses get a bus error. A starvation limiter stops back-to-back instruction fetches from locking out data accesses.

Parameters:
MemStart, 32'h00000000, base address of SRAM window
MemMask, 32'h0000FFFF, window mask; hit when (addr & ~MemMask) == MemStart
MaxInstrStreak, 4, max consecutive instr grants while data_req_i is pending (1..15)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  synchronous active-low reset
instr_req_i  in  1  Ibex instr request
instr_addr_i  in  32  instr address
instr_gnt_o  out  1  instr grant (combinational)
instr_rvalid_o  out  1  instr response valid
instr_rdata_o  out  32  instr read data
instr_err_o  out  1  instr bus error
data_req_i  in  1  Ibex data request
data_we_i  in  1  data write enable
data_be_i  in  4  data byte enables
data_addr_i  in  32  data address
data_wdata_i  in  32  data write data
data_gnt_o  out  1  data grant (combinational)
data_rvalid_o  out  1  data response valid
data_rdata_o  out  32  data read data
data_err_o  out  1  data bus error
mem_req_o  out  1  SRAM request
mem_we_o  out  1  SRAM write enable
mem_be_o  out  4  SRAM byte enables
mem_addr_o  out  32  SRAM address (pass-through)
mem_wdata_o  out  32  SRAM write data
mem_rdata_i  in  32  SRAM read data, valid cycle after mem_req_o

Behaviour:
- Clock/reset: one clock, clk_i. Reset rst_ni is synchronous and active-low. All state is sampled on posedge clk_i only.
- Reset state: rsp_valid_q=0, rsp_owner_q=INSTR, rsp_err_q=0, streak_q=0. All *_rvalid_o, *_err_o = 0. Grants follow the inputs combinationally, so with no requests all gnt and mem_* outputs are 0.
- Arbitration, combinational in each cycle:
  - data wins if data_req_i && (!instr_req_i || streak_q == MaxInstrStreak); otherwise instr wins if instr_req_i.
  - Exactly one gnt is high when any request is present. Never both.
- Winner handling:
  - mem_req_o = winner present && window hit.
  - mem_we_o, mem_be_o and mem_wdata_o come from data on a data win; otherwise they are 0.
  - mem_addr_o is the winner's address, or 0 when there is no winner.
- Out-of-window access: still granted, but mem_req_o=0. Next cycle the owner sees rvalid=1, err=1, rdata=32'h0.
- Response registers, updated every cycle:
  - rsp_valid_q <= winner present.
  - rsp_owner_q <= winner.
  - rsp_err_q <= winner && !hit.
- Response outputs: X_rvalid_o = rsp_valid_q && rsp_owner_q==X. X_rdata_o = mem_rdata_i when (valid && !err), else 0. X_err_o = rsp_valid_q && rsp_err_q && owner==X.
- Latency: 0 cycles req->gnt, 1 cycle gnt->rvalid. Full throughput, one transaction per cycle. Writes also produce rvalid (Ibex requires it).
- Streak counter:
  - On an instr grant while data_req_i=1: streak_q increments, saturating at MaxInstrStreak.
  - On a data grant, or when data_req_i=0: streak_q clears to 0.
- Simultaneous response and new grant in the same cycle is legal; the response registers belong to the previous grant.
- Reset asserted mid-transaction drops any pending response; no rvalid is emitted after reset.

Optional Feature:
ARB_PERF_CNT_EN:
- Defined: adds outputs perf_instr_gnt_o[31:0], perf_data_gnt_o[31:0], perf_data_stall_o[31:0].
  - perf_data_stall_o counts cycles where data_req_i=1 && data_gnt_o=0.
  - All counters wrap at 2^32 and clear on reset.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Instr only: instr_req=1 @0x80 for 3 cycles with mem_rdata=0xA,0xB,0xC -> instr_gnt high each cycle, instr_rvalid cycles 1..3 with rdata 0xA..0xC, data_rvalid never set.
- Data write: data_req=1, we=1, be=4'b0011, addr=0x100, wdata=0xDEADBEEF -> same cycle mem_req=1, mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; data_rvalid=1 next cycle, err=0.
- Starvation: instr_req and data_req held high with MaxInstrStreak=4 -> grant pattern I,I,I,I,D repeating; data_gnt every 5th cycle.
- Out of window: data read at 0x20000 -> data_gnt=1, mem_req=0; next cycle data_rvalid=1, data_err=1, data_rdata=0.
- Reset mid-op: instr granted at cycle N, rst_ni=0 at posedge N+1 -> instr_rvalid stays 0 and streak_q=0 after reset.
- With ARB_PERF_CNT_EN: run the starvation pattern for 10 cycles -> perf_instr_gnt=8, perf_data_gnt=2, perf_data_stall=8.
